// File: rtl/tt_cmd_pkg.sv
// Shared types and pin-map constants for the byte-wide host command responder.
package tt_cmd_pkg;

  typedef enum logic [1:0] {
    OP_STATUS = 2'd0,
    OP_WRITE  = 2'd1,
    OP_READ   = 2'd2,
    OP_ADD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD_ACK   = 2'd1,
    ST_DATA_WAIT = 2'd2,
    ST_DATA_ACK  = 2'd3
  } state_e;

  localparam int REQ_BIT   = 0;
  localparam int ACK_BIT   = 1;
  localparam int CARRY_BIT = 2;
  localparam int BUSY_BIT  = 3;

  localparam logic [7:0] UIO_OE_MASK = 8'b0000_1110;

endpackage

// File: rtl/tt_req_sync.sv
// Multi-flop synchronizer for the host req line with single-cycle
// rise/fall event pulses derived from the synchronized level.
module tt_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   last_r;

  // Shift req through the synchronizer and keep the previous synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      last_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      last_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~last_r;
  assign fall = ~sync_r[SYNC_STAGES-1] & last_r;

endmodule

// File: rtl/tt_byte_cmd_responder.sv
// Pin-level command endpoint: four-phase req/ack handshake that executes
// STATUS/WRITE/READ/ADD commands against a small register file.
module tt_byte_cmd_responder
  import tt_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] ADDR_MASK = 2'(NUM_REGS - 1);

  logic       req_rise_s;
  logic       req_fall_s;
  state_e     state_r;
  op_e        op_r;
  logic [1:0] addr_r;
  logic       pending_r;
  logic       ack_r;
  logic       carry_r;
  logic       busy_r;
  logic [7:0] txn_cnt_r;
  logic [7:0] uo_r;
  logic [7:0] regs_r [4];

  logic [1:0] cmd_addr_s;
  op_e        cmd_op_s;
  logic [8:0] sum_s;
  logic       unused_s;

  tt_req_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (uio_in[REQ_BIT]),
    .rise (req_rise_s),
    .fall (req_fall_s)
  );

  assign cmd_addr_s = ui_in[1:0] & ADDR_MASK;
  assign cmd_op_s   = op_e'(ui_in[7:6]);
  assign sum_s      = {1'b0, regs_r[addr_r]} + {1'b0, ui_in};
  assign unused_s   = ^uio_in[7:1];

  // Handshake FSM, command execution and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_STATUS;
      addr_r    <= 2'd0;
      pending_r <= 1'b0;
      ack_r     <= 1'b0;
      carry_r   <= 1'b0;
      busy_r    <= 1'b0;
      txn_cnt_r <= 8'd0;
      uo_r      <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_rise_s && ena) begin
            ack_r   <= 1'b1;
            state_r <= ST_CMD_ACK;
            op_r    <= cmd_op_s;
            addr_r  <= cmd_addr_s;
            case (cmd_op_s)
              OP_STATUS: begin
                uo_r      <= txn_cnt_r;
                pending_r <= 1'b0;
              end
              OP_READ: begin
                uo_r      <= regs_r[cmd_addr_s];
                pending_r <= 1'b0;
              end
              default: pending_r <= 1'b1;
            endcase
          end
        end
        ST_CMD_ACK: begin
          if (req_fall_s) begin
            ack_r <= 1'b0;
            if (pending_r) begin
              busy_r  <= 1'b1;
              state_r <= ST_DATA_WAIT;
            end else begin
              txn_cnt_r <= txn_cnt_r + 8'd1;
              state_r   <= ST_IDLE;
            end
          end
        end
        ST_DATA_WAIT: begin
          if (req_rise_s) begin
            ack_r     <= 1'b1;
            pending_r <= 1'b0;
            state_r   <= ST_DATA_ACK;
            if (op_r == OP_ADD) begin
              regs_r[addr_r] <= sum_s[7:0];
              carry_r        <= sum_s[8];
              uo_r           <= sum_s[7:0];
            end else begin
              regs_r[addr_r] <= ui_in;
              uo_r           <= ui_in;
            end
          end
        end
        ST_DATA_ACK: begin
          if (req_fall_s) begin
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            txn_cnt_r <= txn_cnt_r + 8'd1;
            state_r   <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Map registered status flags onto their bidirectional pin positions.
  always_comb begin
    uio_out            = 8'h00;
    uio_out[ACK_BIT]   = ack_r;
    uio_out[CARRY_BIT] = carry_r;
    uio_out[BUSY_BIT]  = busy_r;
  end

  assign uo_out = uo_r;
  assign uio_oe = UIO_OE_MASK;

endmodule
